// File: rtl/mult_pkg.sv
// Shared definitions for the Booth multiplier controller: FSM encoding,
// Booth recoding pair constants and the default operand width.
package mult_pkg;

  localparam int DEFAULT_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [1:0] PAIR_ADD  = 2'b01;
  localparam logic [1:0] PAIR_SUB  = 2'b10;
  localparam logic [1:0] PAIR_NOP0 = 2'b00;
  localparam logic [1:0] PAIR_NOP1 = 2'b11;

endpackage

// File: rtl/booth_step.sv
// One radix-2 Booth iteration on the 2W+1-bit product register:
// add/subtract the multiplicand into the upper half, then arithmetic shift right.
module booth_step
  import mult_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [2*WIDTH:0] i_p,
  input  logic [WIDTH-1:0] i_m,
  output logic [2*WIDTH:0] o_p
);

  logic [WIDTH:0] w_u_ext;
  logic [WIDTH:0] w_m_ext;
  logic [WIDTH:0] w_sum;

  // One extra bit keeps U +/- M exact even for M = -2^(W-1).
  assign w_u_ext = {i_p[2*WIDTH], i_p[2*WIDTH:WIDTH+1]};
  assign w_m_ext = {i_m[WIDTH-1], i_m};

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    w_sum = w_u_ext;
    case (i_p[1:0])
      PAIR_ADD: w_sum = w_u_ext + w_m_ext;
      PAIR_SUB: w_sum = w_u_ext - w_m_ext;
      default:  w_sum = w_u_ext;
    endcase
  end

  assign o_p = {w_sum, i_p[WIDTH:1]};

endmodule

// File: rtl/booth_mult_ctrl.sv
// Booth multiply sequencer: loads operands on ctrl_MULT, runs WIDTH iterations,
// then registers the low product word, an overflow flag and a one-cycle ready.
module booth_mult_ctrl
  import mult_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clock,
  input  logic             ctrl_reset,
  input  logic             ctrl_MULT,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           r_state;
  state_t           w_next;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_m;
  logic [2*WIDTH:0] r_p;
  logic [2*WIDTH:0] w_p_next;
  logic [WIDTH-1:0] r_result;
  logic             r_exc;
  logic             w_last;

  booth_step #(.WIDTH(WIDTH)) u_step (
    .i_p (r_p),
    .i_m (r_m),
    .o_p (w_p_next)
  );

  assign w_last = (r_state == ST_RUN) && (r_cnt == LAST);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (!ctrl_reset) r_state <= ST_IDLE;
    else             r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (ctrl_MULT) begin
      w_next = ST_RUN;
    end else begin
      case (r_state)
        ST_IDLE: w_next = ST_IDLE;
        ST_RUN:  w_next = w_last ? ST_DONE : ST_RUN;
        ST_DONE: w_next = ST_IDLE;
        default: w_next = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    busy           = (r_state == ST_RUN);
    data_resultRDY = (r_state == ST_DONE);
  end

  // Result registers are written only on the last step, so a restart keeps the old result visible.
  always_ff @(posedge clock) begin
    if (!ctrl_reset) begin
      r_p      <= '0;
      r_m      <= '0;
      r_cnt    <= '0;
      r_result <= '0;
      r_exc    <= 1'b0;
    end else if (ctrl_MULT) begin
      r_m   <= data_operandA;
      r_p   <= {{WIDTH{1'b0}}, data_operandB, 1'b0};
      r_cnt <= '0;
    end else if (r_state == ST_RUN) begin
      r_p   <= w_p_next;
      r_cnt <= r_cnt + 1'b1;
      if (w_last) begin
        r_result <= w_p_next[WIDTH:1];
        r_exc    <= (w_p_next[2*WIDTH:WIDTH+1] != {WIDTH{w_p_next[WIDTH]}});
      end
    end
  end

  assign data_result    = r_result;
  assign data_exception = r_exc;

endmodule

// File: tb/tb_booth_mult_ctrl.sv
// Directed bench for booth_mult_ctrl: table of signed products with hand-computed
// results, plus restart, reset and back-to-back sequences.
module tb_booth_mult_ctrl;

  localparam int W = 32;

  logic         clock;
  logic         ctrl_reset;
  logic         ctrl_MULT;
  logic [W-1:0] data_operandA;
  logic [W-1:0] data_operandB;
  logic [W-1:0] data_result;
  logic         data_exception;
  logic         data_resultRDY;
  logic         busy;

  int total = 0;
  int bad   = 0;

  booth_mult_ctrl #(.WIDTH(W)) dut (
    .clock          (clock),
    .ctrl_reset     (ctrl_reset),
    .ctrl_MULT      (ctrl_MULT),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .busy           (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic         exc;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", name, got, exp);
    end
  endtask

  // Present a start pulse for exactly one rising edge (the load edge).
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
    ctrl_MULT     = 1'b1;
    data_operandA = a;
    data_operandB = b;
    @(posedge clock); #1;
    ctrl_MULT     = 1'b0;
    data_operandA = $urandom;
    data_operandB = $urandom;
  endtask

  // Count edges after the load edge until RDY; cyc=0 means the bound expired.
  task automatic wait_rdy(input int limit, input logic [W-1:0] hold_val,
                          output int cyc, output bit busy_ok, output bit hold_ok);
    cyc = 0; busy_ok = 1'b1; hold_ok = 1'b1;
    for (int n = 1; n <= limit; n++) begin
      @(posedge clock); #1;
      if (data_resultRDY) begin
        cyc = n;
        if (busy) busy_ok = 1'b0;
        break;
      end
      if (!busy) busy_ok = 1'b0;
      if (data_result !== hold_val) hold_ok = 1'b0;
    end
  endtask

  initial begin
    int cyc;
    bit busy_ok, hold_ok;
    logic [W-1:0] prev;

    vecs[0]  = '{32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0};
    vecs[1]  = '{32'h7FFF_FFFF, 32'd2,        32'hFFFF_FFFE, 1'b1};
    vecs[2]  = '{32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1};
    vecs[3]  = '{32'h8000_0000, 32'd1,        32'h8000_0000, 1'b0};
    vecs[4]  = '{32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b1};
    vecs[5]  = '{32'd0,        32'h9E37_79B9, 32'h0000_0000, 1'b0};
    vecs[6]  = '{32'hFFFF_FFFB, 32'hFFFF_FFFA, 32'd30,        1'b0};
    vecs[7]  = '{32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 1'b1};
    vecs[8]  = '{32'hFFFF_0000, 32'h0000_8000, 32'h8000_0000, 1'b0};
    vecs[9]  = '{32'h0001_0000, 32'h0000_8000, 32'h8000_0000, 1'b1};
    vecs[10] = '{32'h0000_FFFF, 32'h0000_FFFF, 32'hFFFE_0001, 1'b1};

    ctrl_reset = 1'b0; ctrl_MULT = 1'b0;
    data_operandA = '0; data_operandB = '0;
    repeat (3) @(posedge clock);
    #1;
    check("reset_result", data_result, '0);
    check("reset_exc", {31'd0, data_exception}, 32'd0);
    check("reset_rdy", {31'd0, data_resultRDY}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    ctrl_reset = 1'b1;
    @(posedge clock); #1;

    prev = '0;
    for (int i = 0; i < 11; i++) begin
      start_op(vecs[i].a, vecs[i].b);
      check($sformatf("v%0d_busy_after_load", i), {31'd0, busy}, 32'd1);
      wait_rdy(40, prev, cyc, busy_ok, hold_ok);
      check($sformatf("v%0d_latency", i), cyc, 32'd32);
      check($sformatf("v%0d_result", i), data_result, vecs[i].res);
      check($sformatf("v%0d_exc", i), {31'd0, data_exception}, {31'd0, vecs[i].exc});
      check($sformatf("v%0d_busy_profile", i), {31'd0, busy_ok}, 32'd1);
      check($sformatf("v%0d_result_held", i), {31'd0, hold_ok}, 32'd1);
      @(posedge clock); #1;
      check($sformatf("v%0d_rdy_one_cycle", i), {31'd0, data_resultRDY}, 32'd0);
      prev = vecs[i].res;
    end

    // Restart mid-RUN: 5*5 aborted after 10 iterations by 6*7.
    start_op(32'd5, 32'd5);
    wait_rdy(10, prev, cyc, busy_ok, hold_ok);
    check("restart_no_rdy_first", cyc, 32'd0);
    start_op(32'd6, 32'd7);
    wait_rdy(40, prev, cyc, busy_ok, hold_ok);
    check("restart_latency", cyc, 32'd32);
    check("restart_result", data_result, 32'd42);
    check("restart_held_old", {31'd0, hold_ok}, 32'd1);
    @(posedge clock); #1;
    check("restart_single_rdy", {31'd0, data_resultRDY}, 32'd0);

    // Reset at iteration 15 aborts RUN and clears outputs.
    start_op(32'd123, 32'd456);
    repeat (15) @(posedge clock);
    #1;
    ctrl_reset = 1'b0;
    @(posedge clock); #1;
    check("midreset_result", data_result, '0);
    check("midreset_exc", {31'd0, data_exception}, 32'd0);
    check("midreset_rdy", {31'd0, data_resultRDY}, 32'd0);
    check("midreset_busy", {31'd0, busy}, 32'd0);
    // Reset coincident with a start request must not load.
    ctrl_MULT = 1'b1; data_operandA = 32'd9; data_operandB = 32'd9;
    @(posedge clock); #1;
    ctrl_MULT = 1'b0; ctrl_reset = 1'b1;
    check("reset_vs_mult_busy", {31'd0, busy}, 32'd0);
    wait_rdy(40, '0, cyc, busy_ok, hold_ok);
    check("reset_vs_mult_no_rdy", cyc, 32'd0);

    // Back-to-back: 3*4, then -2*9 started in the DONE cycle.
    start_op(32'd3, 32'd4);
    wait_rdy(40, '0, cyc, busy_ok, hold_ok);
    check("b2b_first_latency", cyc, 32'd32);
    check("b2b_first_result", data_result, 32'd12);
    start_op(32'hFFFF_FFFE, 32'd9);
    check("b2b_busy_after_reload", {31'd0, busy}, 32'd1);
    check("b2b_rdy_dropped", {31'd0, data_resultRDY}, 32'd0);
    wait_rdy(40, 32'd12, cyc, busy_ok, hold_ok);
    check("b2b_second_latency", cyc, 32'd32);
    check("b2b_second_result", data_result, 32'hFFFF_FFEE);
    check("b2b_second_exc", {31'd0, data_exception}, 32'd0);
    check("b2b_hold_12", {31'd0, hold_ok}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
